// File: rtl/clock_mode_ctrl.sv
// Mode controller and display selector for the clock top level: debounced
// mode decode, sub-block strobes, circular lap buffer and time-zone display.
//
//  state          | meaning
//  ---------------+--------------------------------------------------
//  M_NORMAL       | show running local time
//  M_SET_TIME     | time-set sub-block active, show userTime
//  M_STOPWATCH    | stopper running, show stopperTime
//  M_LAP_CAPTURE  | stopper running, KEY[0] stores a lap, KEY[1] clears
//  M_LAP_RECALL   | stopper running, show stored laps newest first
//  M_CD_SET       | countdown set sub-block active, show cdTime
//  M_CD_RUN       | countdown running, show cdTime
//  M_ALARM_SET    | alarm-set sub-block active, show alarmTime
//  M_DATE         | date-set sub-block active, show dateVal
//  M_FLASH        | flash display, display word frozen
//  M_ZONE         | show local time shifted by the selected zone offset
module clock_mode_ctrl #(
  parameter int          TW         = 32,
  parameter int          DAY_SEC    = 86400,
  parameter int          N_LAPS     = 4,
  parameter int          N_ZONES    = 8,
  // zone 7 .. zone 0 = -5, 2, 10, 5, -1, 6, -2, -7 hours
  parameter logic [39:0] ZONE_HRS   = {5'h1B, 5'h02, 5'h0A, 5'h05, 5'h1F, 5'h06, 5'h1E, 5'h19},
  parameter int          STABLE_CYC = 1024
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [9:0]                   SW,
  input  logic [1:0]                   KEY,
  input  logic [TW-1:0]                nowTime,
  input  logic [TW-1:0]                stopperTime,
  input  logic [TW-1:0]                userTime,
  input  logic [TW-1:0]                alarmTime,
  input  logic [TW-1:0]                cdTime,
  input  logic [TW-1:0]                dateVal,
  input  logic [1:0]                   setTimeStage,
  input  logic [1:0]                   setAlarmStage,
  input  logic [1:0]                   setCDStage,
  input  logic [1:0]                   setDateStage,
  output logic [TW-1:0]                Out,
  output logic [1:0]                   timerState,
  output logic                         activeState,
  output logic                         DateOrTime,
  output logic                         flashFlag,
  output logic                         startSetTime,
  output logic                         startSetAlarm,
  output logic                         startCD,
  output logic                         startDate,
  output logic                         stopperRun,
  output logic                         modeChange,
  output logic [$clog2(N_LAPS+1)-1:0]  lapCount
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int PW = $clog2(N_LAPS);
  localparam int LW = $clog2(N_LAPS + 1);
  localparam logic signed [TW+1:0] SEC_PER_HR = (TW+2)'(3600);
  localparam logic signed [TW+1:0] DAY_S      = (TW+2)'(DAY_SEC);

  typedef enum logic [3:0] {
    M_NORMAL, M_SET_TIME, M_STOPWATCH, M_LAP_CAPTURE, M_LAP_RECALL, M_CD_SET,
    M_CD_RUN, M_ALARM_SET, M_DATE, M_FLASH, M_ZONE
  } mode_t;

  mode_t           mode, modeNext;
  logic [2:0]      zoneIdx, zoneIdxNext;
  logic            zoneLocal, zoneLocalNext;
  logic            changeNext;

  logic [8:0]      swPrev;
  logic [CW-1:0]   stableCnt;
  logic            stableHit;

  logic            codeLegal;
  mode_t           codeMode;
  logic [2:0]      codeZoneIdx;
  logic            codeZoneLocal;

  logic [TW-1:0]   laps [N_LAPS];
  logic [PW-1:0]   wrPtr, rdIdx, recallIdx;
  logic [LW-1:0]   rdNext;
  logic [TW-1:0]   recallVal;

  logic signed [4:0]    zoneHrs;
  logic signed [TW+1:0] zoneOffs, zoneSum, zoneAdj;
  logic [TW-1:0]        zoneTime;
  logic [TW-1:0]        outNext;

  // Stability filter: the code must hold unchanged until the counter tops out.
  assign stableHit = (stableCnt == CW'(STABLE_CYC - 1));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      swPrev    <= '0;
      stableCnt <= '0;
    end else begin
      swPrev <= SW[8:0];
      if (SW[8:0] != swPrev)
        stableCnt <= '0;
      else if (!stableHit)
        stableCnt <= stableCnt + CW'(1);
    end
  end

  always_comb begin
    codeLegal     = 1'b0;
    codeMode      = M_NORMAL;
    codeZoneIdx   = '0;
    codeZoneLocal = 1'b0;
    case (swPrev)
      9'd0:  begin codeLegal = 1'b1; codeMode = M_NORMAL;      end
      9'd1:  begin codeLegal = 1'b1; codeMode = M_SET_TIME;    end
      9'd2:  begin codeLegal = 1'b1; codeMode = M_STOPWATCH;   end
      9'd4:  begin codeLegal = 1'b1; codeMode = M_LAP_CAPTURE; end
      9'd5:  begin codeLegal = 1'b1; codeMode = M_LAP_RECALL;  end
      9'd8:  begin codeLegal = 1'b1; codeMode = M_CD_SET;      end
      9'd9:  begin codeLegal = 1'b1; codeMode = M_CD_RUN;      end
      9'd16: begin codeLegal = 1'b1; codeMode = M_ALARM_SET;   end
      9'd32: begin codeLegal = 1'b1; codeMode = M_DATE;        end
      9'd64: begin codeLegal = 1'b1; codeMode = M_FLASH;       end
      default: begin
        if (swPrev[8]) begin
          if (swPrev[7:0] == 8'd0) begin
            codeLegal     = 1'b1;
            codeMode      = M_ZONE;
            codeZoneLocal = 1'b1;
          end else begin
            for (int k = 0; k < 8; k++) begin
              if (k < N_ZONES && swPrev[7:0] == 8'(1 << k)) begin
                codeLegal   = 1'b1;
                codeMode    = M_ZONE;
                codeZoneIdx = 3'(k);
              end
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      mode       <= M_NORMAL;
      zoneIdx    <= '0;
      zoneLocal  <= 1'b0;
      modeChange <= 1'b0;
    end else begin
      mode       <= modeNext;
      zoneIdx    <= zoneIdxNext;
      zoneLocal  <= zoneLocalNext;
      modeChange <= changeNext;
    end
  end

  // A different zone selection counts as a mode change.
  always_comb begin
    modeNext      = mode;
    zoneIdxNext   = zoneIdx;
    zoneLocalNext = zoneLocal;
    changeNext    = 1'b0;
    if (stableHit && codeLegal) begin
      modeNext      = codeMode;
      zoneIdxNext   = codeZoneIdx;
      zoneLocalNext = codeZoneLocal;
      changeNext    = (codeMode != mode) ||
                      (codeMode == M_ZONE &&
                       (codeZoneLocal != zoneLocal || codeZoneIdx != zoneIdx));
    end

    timerState    = '0;
    activeState   = 1'b1;
    DateOrTime    = 1'b0;
    flashFlag     = 1'b0;
    startSetTime  = 1'b0;
    startSetAlarm = 1'b0;
    startCD       = 1'b0;
    startDate     = 1'b0;
    stopperRun    = 1'b0;
    case (mode)
      M_SET_TIME:  begin timerState = setTimeStage;  activeState = 1'b0; startSetTime  = 1'b1; end
      M_ALARM_SET: begin timerState = setAlarmStage; activeState = 1'b0; startSetAlarm = 1'b1; end
      M_CD_SET:    begin timerState = setCDStage;    activeState = 1'b0; end
      M_CD_RUN:    startCD = 1'b1;
      M_DATE: begin
        timerState  = setDateStage;
        activeState = 1'b0;
        DateOrTime  = 1'b1;
        startDate   = 1'b1;
      end
      M_FLASH:     flashFlag = 1'b1;
      M_STOPWATCH, M_LAP_CAPTURE, M_LAP_RECALL: stopperRun = 1'b1;
      default: ;
    endcase
    // Sub-blocks see a clean low cycle between two modes.
    if (modeChange) begin
      startSetTime  = 1'b0;
      startSetAlarm = 1'b0;
      startCD       = 1'b0;
      startDate     = 1'b0;
      stopperRun    = 1'b0;
    end
  end

  assign rdNext    = LW'(rdIdx) + LW'(1);
  assign recallIdx = wrPtr - PW'(1) - rdIdx;
  assign recallVal = (lapCount == '0) ? '0 : laps[recallIdx];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < N_LAPS; i++) laps[i] <= '0;
      wrPtr    <= '0;
      rdIdx    <= '0;
      lapCount <= '0;
    end else begin
      if (mode == M_LAP_CAPTURE && KEY[1]) begin
        for (int i = 0; i < N_LAPS; i++) laps[i] <= '0;
        wrPtr    <= '0;
        lapCount <= '0;
      end else if (mode == M_LAP_CAPTURE && KEY[0]) begin
        laps[wrPtr] <= stopperTime;
        wrPtr       <= wrPtr + PW'(1);
        if (lapCount != LW'(N_LAPS))
          lapCount <= lapCount + LW'(1);
      end

      if (modeNext == M_LAP_RECALL && mode != M_LAP_RECALL)
        rdIdx <= '0;
      else if (mode == M_LAP_RECALL && KEY[0] && lapCount != '0)
        rdIdx <= (rdNext >= lapCount) ? '0 : PW'(rdNext);
    end
  end

  // Signed sum at TW+2 bits; a single correction lands back inside one day.
  always_comb begin
    zoneHrs  = ZONE_HRS[5*zoneIdx +: 5];
    zoneOffs = (TW+2)'(zoneHrs) * SEC_PER_HR;
    zoneSum  = $signed({2'b00, nowTime}) + zoneOffs;
    zoneAdj  = zoneSum;
    if (zoneSum < 0)
      zoneAdj = zoneSum + DAY_S;
    else if (zoneSum >= DAY_S)
      zoneAdj = zoneSum - DAY_S;
    zoneTime = TW'(zoneAdj);
  end

  always_comb begin
    outNext = Out;
    if (!SW[9]) begin
      case (mode)
        M_NORMAL:                   outNext = nowTime;
        M_SET_TIME:                 outNext = userTime;
        M_ALARM_SET:                outNext = alarmTime;
        M_CD_SET, M_CD_RUN:         outNext = cdTime;
        M_DATE:                     outNext = dateVal;
        M_STOPWATCH, M_LAP_CAPTURE: outNext = stopperTime;
        M_LAP_RECALL:               outNext = recallVal;
        M_ZONE:                     outNext = zoneLocal ? nowTime : zoneTime;
        default:                    outNext = Out;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) Out <= '0;
    else     Out <= outNext;
  end

endmodule
